// File: rtl/imm_gen_pipe_if.sv
// Handshake/data bundle for imm_gen_pipe: fetch-side input, decode-side output,
// and the statistics counters.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] ill_cnt;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal,
           acc_cnt, ill_cnt
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal,
           acc_cnt, ill_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I immediate decoder followed by a STAGES-deep elastic valid/ready pipeline
// with flush, illegal-opcode flagging and accept/illegal counters.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  imm_gen_pipe_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [6:0]       w_op;
  logic [2:0]       w_fmt;
  logic             w_ill;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic             w_accept;
  logic             w_rdy_acc;
  logic [STAGES-1:0] w_rdy;

  logic [STAGES-1:0] w_up_v;
  logic [31:0]       w_up_instr [STAGES];
  logic [XLEN-1:0]   w_up_imm   [STAGES];
  logic [2:0]        w_up_fmt   [STAGES];
  logic              w_up_ill   [STAGES];

  logic [STAGES-1:0] r_v;
  logic [31:0]       r_instr [STAGES];
  logic [XLEN-1:0]   r_imm   [STAGES];
  logic [2:0]        r_fmt   [STAGES];
  logic              r_ill   [STAGES];
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [CNT_W-1:0]  r_ill_cnt;

  assign w_op = bus.instr[6:0];

  always_comb begin
    w_fmt = FMT_ILL;
    unique case (w_op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: w_fmt = FMT_I;
      OP_IMM32:                            w_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      OP_STORE:                            w_fmt = FMT_S;
      OP_BRANCH:                           w_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    w_fmt = FMT_U;
      OP_JAL:                              w_fmt = FMT_J;
      OP_OP:                               w_fmt = FMT_R;
      OP_OP32:                             w_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                             w_fmt = FMT_ILL;
    endcase
  end

  assign w_ill = (w_fmt == FMT_ILL);

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
      FMT_S: w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      FMT_B: w_imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                        bus.instr[30:25], bus.instr[11:8], 1'b0};
      FMT_U: w_imm32 = {bus.instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                        bus.instr[20], bus.instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Every 32-bit immediate already carries instr[31] in its MSB, so one signed
  // widening covers all formats, U included, for XLEN=64.
  assign w_imm = XLEN'($signed(w_imm32));

  // rdy[k] = !v[k] || rdy[k+1], unrolled from the output end so no bit reads another.
  always_comb begin
    w_rdy     = '0;
    w_rdy_acc = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy_acc = w_rdy_acc || !r_v[k];
      w_rdy[k]  = w_rdy_acc;
    end
  end

  assign w_accept = bus.in_valid && w_rdy[0];

  always_comb begin
    w_up_v        = '0;
    w_up_v[0]     = bus.in_valid;
    w_up_instr[0] = bus.instr;
    w_up_imm[0]   = w_imm;
    w_up_fmt[0]   = w_fmt;
    w_up_ill[0]   = w_ill;
    for (int k = 1; k < STAGES; k++) begin
      w_up_v[k]     = r_v[k-1];
      w_up_instr[k] = r_instr[k-1];
      w_up_imm[k]   = r_imm[k-1];
      w_up_fmt[k]   = r_fmt[k-1];
      w_up_ill[k]   = r_ill[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v       <= '0;
      r_acc_cnt <= '0;
      r_ill_cnt <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_instr[k] <= '0;
        r_imm[k]   <= '0;
        r_fmt[k]   <= '0;
        r_ill[k]   <= 1'b0;
      end
    end else begin
      if (w_accept && !flush) begin
        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        if (w_ill) r_ill_cnt <= r_ill_cnt + CNT_W'(1);
      end
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_v[k]     <= w_up_v[k];
          r_instr[k] <= w_up_instr[k];
          r_imm[k]   <= w_up_imm[k];
          r_fmt[k]   <= w_up_fmt[k];
          r_ill[k]   <= w_up_ill[k];
        end
      end
      // Only valid bits are cleared; stale data behind them is harmless.
      if (flush) r_v <= '0;
    end
  end

  assign bus.in_ready    = w_rdy[0];
  assign bus.out_valid   = r_v[STAGES-1];
  assign bus.out_instr   = r_instr[STAGES-1];
  assign bus.out_imm     = r_imm[STAGES-1];
  assign bus.out_fmt     = r_fmt[STAGES-1];
  assign bus.out_illegal = r_ill[STAGES-1];
  assign bus.acc_cnt     = r_acc_cnt;
  assign bus.ill_cnt     = r_ill_cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32/STAGES=2 instance with a queue-based
// monitor, plus an XLEN=64/STAGES=3 instance for wide sign extension and async reset.
module tb_imm_gen_pipe;
  localparam int ST32 = 2;
  localparam int ST64 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst64, flush, flush64;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(16)) b64 ();

  imm_gen_pipe #(.XLEN(32), .STAGES(ST32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .STAGES(ST64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst64), .flush(flush64), .bus(b64));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    int          acc_cyc;
    bit          lat_chk;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   exp_acc = 0;
  int   exp_ill = 0;
  int   base;
  bit   lat_mode = 0;
  bit   found;

  logic [31:0] vi [16] = '{32'h0080af03, 32'hff80af03, 32'h0200a283, 32'hfe20aa23,
                           32'hfeb289e3, 32'h123450b7, 32'hffdff06f, 32'h0000007f,
                           32'h002081b3, 32'h00001017, 32'h00008067, 32'h00100073,
                           32'h0010009b, 32'h0000003b, 32'h7ff00013, 32'h800000b7};
  logic [31:0] vm [16] = '{32'h00000008, 32'hfffffff8, 32'h00000020, 32'hfffffff4,
                           32'hfffffff2, 32'h12345000, 32'hfffffffc, 32'h00000000,
                           32'h00000000, 32'h00001000, 32'h00000000, 32'h00000001,
                           32'h00000000, 32'h00000000, 32'h000007ff, 32'h80000000};
  logic [2:0]  vf [16] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7,
                           3'd0, 3'd4, 3'd1, 3'd1, 3'd7, 3'd7, 3'd1, 3'd4};

  logic [31:0] wi [4] = '{32'hff80af03, 32'h800000b7, 32'h0010009b, 32'h0000003b};
  logic [63:0] wm [4] = '{64'hfffffffffffffff8, 64'hffffffff80000000,
                          64'h0000000000000001, 64'h0000000000000000};
  logic [2:0]  wf [4] = '{3'd1, 3'd4, 3'd1, 3'd0};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && b32.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got instr %h expected none", b32.out_instr);
      end else if (b32.out_ready) begin
        mon_e = q.pop_front();
        chk("out_instr", 64'(b32.out_instr), 64'(mon_e.instr));
        chk("out_imm", 64'(b32.out_imm), 64'(mon_e.imm));
        chk("out_fmt", 64'(b32.out_fmt), 64'(mon_e.fmt));
        chk("out_illegal", 64'(b32.out_illegal), 64'(mon_e.ill));
        if (mon_e.lat_chk) chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(ST32 - 1));
      end else begin
        chk("stall_instr", 64'(b32.out_instr), 64'(q[0].instr));
      end
    end
  end

  task automatic send32(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] fmt);
    bit   ok;
    exp_t e;
    ok = 0;
    b32.instr    = ins;
    b32.in_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = b32.in_ready;
      @(posedge clk);
    end
    #1;
    b32.in_valid = 1'b0;
    if (!ok) begin
      chk("send_timeout", 64'(0), 64'(1));
    end else begin
      e.instr   = ins;
      e.imm     = imm;
      e.fmt     = fmt;
      e.ill     = (fmt == 3'd7);
      e.acc_cyc = cyc;
      e.lat_chk = lat_mode;
      q.push_back(e);
      exp_acc++;
      if (fmt == 3'd7) exp_ill++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() > 0; t++) @(negedge clk);
    chk("drain_left", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rst64 = 1; flush = 0; flush64 = 0;
    b32.in_valid = 0; b32.instr = '0; b32.out_ready = 1;
    b64.in_valid = 0; b64.instr = '0; b64.out_ready = 1;
    #12;
    chk("rst_out_valid", 64'(b32.out_valid), 64'(0));
    chk("rst_out_instr", 64'(b32.out_instr), 64'(0));
    chk("rst_out_imm", 64'(b32.out_imm), 64'(0));
    chk("rst_out_fmt", 64'(b32.out_fmt), 64'(0));
    chk("rst_out_illegal", 64'(b32.out_illegal), 64'(0));
    chk("rst_acc_cnt", 64'(b32.acc_cnt), 64'(0));
    chk("rst_ill_cnt", 64'(b32.ill_cnt), 64'(0));
    @(posedge clk); #1;
    rst = 0; rst64 = 0;
    chk("rst_in_ready", 64'(b32.in_ready), 64'(1));

    // Back-to-back stream of every format with latency check
    lat_mode = 1;
    for (int i = 0; i < 16; i++) send32(vi[i], vm[i], vf[i]);
    drain();
    lat_mode = 0;
    chk("acc_cnt_stream", 64'(b32.acc_cnt), 64'(exp_acc));
    chk("ill_cnt_stream", 64'(b32.ill_cnt), 64'(exp_ill));

    // Backpressure: pipe holds two entries, releases all five in order
    @(posedge clk); #1;
    b32.out_ready = 0;
    base = exp_acc;
    fork
      begin
        for (int k = 1; k <= 5; k++) send32({12'(k), 20'h00003}, 32'(k), 3'd1);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_in_ready", 64'(b32.in_ready), 64'(0));
        chk("bp_out_valid", 64'(b32.out_valid), 64'(1));
        chk("bp_acc_cnt", 64'(b32.acc_cnt), 64'(base + 2));
        @(posedge clk); #1;
        b32.out_ready = 1;
      end
    join
    drain();
    chk("bp_acc_cnt_final", 64'(b32.acc_cnt), 64'(base + 5));

    // Flush with a simultaneous accept
    @(posedge clk); #1;
    b32.out_ready = 0;
    send32(32'h00a00093, 32'h0000000a, 3'd1);
    send32(32'h00b00093, 32'h0000000b, 3'd1);
    flush = 1; b32.in_valid = 1; b32.instr = 32'h0000007f; b32.out_ready = 1;
    @(posedge clk); #1;
    flush = 0; b32.in_valid = 0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(b32.out_valid), 64'(0));
    chk("flush_in_ready", 64'(b32.in_ready), 64'(1));
    chk("flush_acc_cnt", 64'(b32.acc_cnt), 64'(exp_acc));
    chk("flush_ill_cnt", 64'(b32.ill_cnt), 64'(exp_ill));
    repeat (3) @(negedge clk);
    chk("flush_quiet", 64'(b32.out_valid), 64'(0));
    @(posedge clk); #1;
    send32(32'hfff00013, 32'hffffffff, 3'd1);
    drain();

    // XLEN=64 sign extension and wide-only opcodes
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b64.instr = wi[i]; b64.in_valid = 1;
      @(posedge clk); #1;
      b64.in_valid = 0;
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        found = b64.out_valid;
      end
      chk("x64_valid", 64'(found), 64'(1));
      chk("x64_imm", b64.out_imm, wm[i]);
      chk("x64_fmt", 64'(b64.out_fmt), 64'(wf[i]));
    end
    chk("x64_acc_cnt", 64'(b64.acc_cnt), 64'(4));

    // Asynchronous reset with entries in flight
    @(posedge clk); #1;
    b64.out_ready = 0;
    b64.instr = 32'h0000007f; b64.in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    b64.in_valid = 0;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      found = b64.out_valid;
    end
    chk("x64_pre_rst_valid", 64'(found), 64'(1));
    chk("x64_pre_rst_ill", 64'(b64.ill_cnt), 64'(2));
    @(posedge clk); #3;
    rst64 = 1;
    #1;
    chk("async_rst_out_valid", 64'(b64.out_valid), 64'(0));
    chk("async_rst_acc_cnt", 64'(b64.acc_cnt), 64'(0));
    chk("async_rst_ill_cnt", 64'(b64.ill_cnt), 64'(0));
    chk("async_rst_out_imm", b64.out_imm, 64'(0));
    @(posedge clk); #1;
    rst64 = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
